// File: rtl/remote_cmd_sequencer.sv
// remote_cmd_sequencer
//   Queues 16-bit KnightsTour commands and issues them one at a time through
//   the RemoteComm handshake. After each command it waits for the 8-bit
//   response and compares it with ACK_RESP. The sequence stops on a timeout
//   or on a bad response.
//
// Ports
//   clk, rst           system clock; asynchronous active-high reset
//   cmd_in, cmd_wr     command enqueue (dropped while fifo_full)
//   fifo_full/empty    FIFO status
//   start, abort       begin draining the FIFO / stop and flush
//   busy               sequencer not idle
//   cmd, send_cmd      command and 1-cycle send strobe to RemoteComm
//   cmd_sent           RemoteComm finished transmitting
//   resp_rdy, resp     RemoteComm response valid / byte
//   clr_rx_rdy         1-cycle acknowledge of the response
//   done               1-cycle pulse when a sequence ends
//   err, err_code      sticky error; 01 timeout, 10 bad response
//   err_resp           offending response byte (0 for timeout)
//   ok_cnt             acknowledged commands since start, saturating
//
// Build option
//   REMOTE_CMD_SEQ_RETRY_EN: a failed command is re-sent up to MAX_RETRY
//   more times before the error becomes final.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start
// S_LOAD      | pop FIFO head into cmd
// S_SEND      | send_cmd high, load the timeout timer
// S_WAIT_SENT | waiting for cmd_sent, timer running
// S_WAIT_RESP | waiting for resp_rdy, timer running
// S_CHECK     | clr_rx_rdy high, compare response
// S_FINISH    | raise done, return to idle

module remote_cmd_sequencer #(
  parameter int         DEPTH        = 8,
  parameter int         TIMEOUT_CLKS = 1000000,
  parameter logic [7:0] ACK_RESP     = 8'hA5,
  parameter int         MAX_RETRY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd_in,
  input  logic        cmd_wr,
  output logic        fifo_full,
  output logic        fifo_empty,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic [15:0] cmd,
  output logic        send_cmd,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_rx_rdy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_resp,
  output logic [7:0]  ok_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CLKS);
  // Down-counter reload chosen so that done lands exactly TIMEOUT_CLKS
  // cycles after the send_cmd pulse (SEND, wait cycles, FINISH, done).
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CLKS - 3);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_CHECK, S_FINISH
  } state_t;

  state_t            state;
  logic [15:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic [TMR_W-1:0]  tmr;
  logic [7:0]        resp_q;
  logic              fail;
  logic [1:0]        fail_code;
  logic              retry_ok;

  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign busy       = (state != S_IDLE);
  // Flush wins over a simultaneous push.
  assign push       = cmd_wr && !fifo_full && !abort;
  assign pop        = (state == S_LOAD) && !abort;

`ifdef REMOTE_CMD_SEQ_RETRY_EN
  localparam int ATT_W = $clog2(MAX_RETRY + 2) + 1;
  logic [ATT_W-1:0] attempts;
  assign retry_ok = (attempts <= ATT_W'(MAX_RETRY));
`else
  // MAX_RETRY has no effect when retries are not built in.
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A response arriving on the last timer cycle still counts as in time.
  always_comb begin
    fail      = 1'b0;
    fail_code = 2'b00;
    case (state)
      S_WAIT_SENT: if (tmr == '0) begin
        fail      = 1'b1;
        fail_code = 2'b01;
      end
      S_WAIT_RESP: if (!resp_rdy && tmr == '0) begin
        fail      = 1'b1;
        fail_code = 2'b01;
      end
      S_CHECK: if (resp_q != ACK_RESP) begin
        fail      = 1'b1;
        fail_code = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd        <= '0;
      send_cmd   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      err_resp   <= '0;
      ok_cnt     <= '0;
      tmr        <= '0;
      resp_q     <= '0;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
      attempts   <= '0;
`endif
    end else begin
      send_cmd   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        if (state != S_IDLE) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        // Release a response RemoteComm is still holding for us.
        clr_rx_rdy <= resp_rdy && (state == S_WAIT_SENT || state == S_WAIT_RESP);
      end else if (fail) begin
        if (retry_ok) begin
          send_cmd <= 1'b1;
          state    <= S_SEND;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
          attempts <= attempts + 1'b1;
`endif
        end else begin
          err      <= 1'b1;
          err_code <= fail_code;
          err_resp <= (fail_code == 2'b10) ? resp_q : 8'h00;
          state    <= S_FINISH;
        end
      end else begin
        case (state)
          S_IDLE: if (start) begin
            err      <= 1'b0;
            err_code <= '0;
            err_resp <= '0;
            ok_cnt   <= '0;
            state    <= fifo_empty ? S_FINISH : S_LOAD;
          end
          S_LOAD: begin
            cmd      <= mem[rd_ptr];
            send_cmd <= 1'b1;
            state    <= S_SEND;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
            attempts <= ATT_W'(1);
`endif
          end
          S_SEND: begin
            tmr   <= TMR_LOAD;
            state <= S_WAIT_SENT;
          end
          S_WAIT_SENT: begin
            tmr <= tmr - 1'b1;
            if (cmd_sent) state <= S_WAIT_RESP;
          end
          S_WAIT_RESP: begin
            if (resp_rdy) begin
              resp_q     <= resp;
              clr_rx_rdy <= 1'b1;
              state      <= S_CHECK;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          S_CHECK: begin
            if (ok_cnt != 8'hFF) ok_cnt <= ok_cnt + 1'b1;
            state <= fifo_empty ? S_FINISH : S_LOAD;
          end
          S_FINISH: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_remote_cmd_sequencer.sv
module tb_remote_cmd_sequencer;

  localparam int         DEPTH     = 8;
  localparam int         TIMEOUT   = 100;
  localparam int         MAX_RETRY = 2;
  localparam logic [7:0] ACK       = 8'hA5;
`ifdef REMOTE_CMD_SEQ_RETRY_EN
  localparam int MAX_TRIES = MAX_RETRY + 1;
`else
  localparam int MAX_TRIES = 1;
`endif

  logic        clk, rst;
  logic [15:0] cmd_in;
  logic        cmd_wr, fifo_full, fifo_empty, start, abort, busy;
  logic [15:0] cmd;
  logic        send_cmd, cmd_sent, resp_rdy;
  logic [7:0]  resp;
  logic        clr_rx_rdy, done, err;
  logic [1:0]  err_code;
  logic [7:0]  err_resp, ok_cnt;

  remote_cmd_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT_CLKS(TIMEOUT), .ACK_RESP(ACK), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_wr(cmd_wr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .start(start), .abort(abort),
    .busy(busy), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .resp_rdy(resp_rdy), .resp(resp), .clr_rx_rdy(clr_rx_rdy), .done(done),
    .err(err), .err_code(err_code), .err_resp(err_resp), .ok_cnt(ok_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // observation of the RemoteComm side
  logic [15:0] sent_q[$];
  int n_send, n_clr, n_done, t_send, t_first_send, t_done, t_start;
  // responder behaviour
  logic [15:0] cmd_list[$];
  logic [7:0]  resp_list[$];
  int  resp_idx, phase, dly;
  bit  auto_en, no_resp, noise_en;
  // reference model results
  logic [15:0] exp_sent[$];
  int          exp_ok, exp_left;
  logic        exp_err;
  logic [1:0]  exp_code;
  logic [7:0]  exp_eresp;

  // Outcome of a whole run derived from the command list and the responses
  // the remote side will give, in order.
  function automatic void model_run();
    int ri, tries;
    bit good;
    logic [7:0] r, last_bad;
    exp_sent.delete();
    exp_ok = 0; exp_err = 1'b0; exp_code = 2'b00; exp_eresp = 8'h00; exp_left = 0;
    ri = 0; last_bad = 8'h00;
    for (int i = 0; i < cmd_list.size() && !exp_err; i++) begin
      tries = 0; good = 1'b0;
      while (!good && tries < MAX_TRIES) begin
        r = (ri < resp_list.size()) ? resp_list[ri] : ACK;
        ri++;
        exp_sent.push_back(cmd_list[i]);
        tries++;
        if (r == ACK) good = 1'b1; else last_bad = r;
      end
      if (good) begin
        if (exp_ok < 255) exp_ok++;
      end else begin
        exp_err = 1'b1; exp_code = 2'b10; exp_eresp = last_bad;
        exp_left = cmd_list.size() - i - 1;
      end
    end
  endfunction

  task automatic raise_resp();
    resp = (resp_idx < resp_list.size()) ? resp_list[resp_idx] : ACK;
    resp_idx++;
    resp_rdy = 1'b1;
    phase = 3;
  endtask

  // One clock: observe at the falling edge, then drive the remote side.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (send_cmd) begin
      if (n_send == 0) t_first_send = cyc;
      n_send++; sent_q.push_back(cmd); t_send = cyc;
    end
    if (clr_rx_rdy) n_clr++;
    if (done) begin n_done++; t_done = cyc; end
    cmd_sent = 1'b0;
    if (auto_en) begin
      if (send_cmd) begin
        resp_rdy = 1'b0; phase = 1; dly = $urandom_range(1, 3);
      end else begin
        case (phase)
          1: begin
            dly--;
            if (dly == 0) begin
              cmd_sent = 1'b1;
              if (no_resp) phase = 0;
              else begin
                dly = $urandom_range(0, 2);
                if (dly == 0) raise_resp(); else phase = 2;
              end
            end
          end
          2: begin dly--; if (dly == 0) raise_resp(); end
          3: if (clr_rx_rdy) begin resp_rdy = 1'b0; phase = 0; end
          default: ;
        endcase
      end
      if (noise_en) start = busy && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic clear_stats();
    sent_q.delete(); cmd_list.delete(); resp_list.delete();
    n_send = 0; n_clr = 0; n_done = 0; t_send = -1; t_first_send = -1; t_done = -1;
    resp_idx = 0; phase = 0; dly = 0; no_resp = 1'b0; noise_en = 1'b0; auto_en = 1'b1;
  endtask

  task automatic push(input logic [15:0] c);
    cmd_in = c; cmd_wr = 1'b1; step(); cmd_wr = 1'b0;
  endtask

  task automatic do_start();
    t_start = cyc; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin step(); k++; end
    checks++;
    if (n_done == 0) begin errors++; $display("FAIL %s_done: no done within %0d cycles", name, budget); end
    repeat (3) step();
  endtask

  task automatic flush_idle();
    abort = 1'b1; step(); abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", fifo_empty); end
    checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL rst_full: got %b want 0", fifo_full); end
    checks++; if (send_cmd !== 1'b0)   begin errors++; $display("FAIL rst_send: got %b want 0", send_cmd); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (cmd !== 16'h0)       begin errors++; $display("FAIL rst_cmd: got %h want 0", cmd); end
    checks++; if (ok_cnt !== 8'h0)     begin errors++; $display("FAIL rst_ok: got %0d want 0", ok_cnt); end
  endtask

  task automatic test_empty_start();
    clear_stats();
    do_start();
    run_until_done("empty", 20);
    checks++; if (t_done !== t_start + 2) begin errors++; $display("FAIL empty_latency: got %0d want %0d", t_done - t_start, 2); end
    checks++; if (n_send !== 0)  begin errors++; $display("FAIL empty_sends: got %0d want 0", n_send); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL empty_err: got %b want 0", err); end
    checks++; if (n_done !== 1)  begin errors++; $display("FAIL empty_ndone: got %0d want 1", n_done); end
  endtask

  task automatic test_single();
    clear_stats();
    push(16'h2000);
    do_start();
    run_until_done("single", 500);
    checks++; if (t_first_send !== t_start + 2) begin errors++; $display("FAIL single_send_lat: got %0d want 2", t_first_send - t_start); end
    checks++; if (n_send !== 1 || sent_q[0] !== 16'h2000) begin errors++; $display("FAIL single_send: got %0d pulses cmd %h want 1 pulse cmd 2000", n_send, sent_q[0]); end
    checks++; if (n_clr !== 1)    begin errors++; $display("FAIL single_clr: got %0d want 1", n_clr); end
    checks++; if (n_done !== 1)   begin errors++; $display("FAIL single_ndone: got %0d want 1", n_done); end
    checks++; if (ok_cnt !== 8'd1) begin errors++; $display("FAIL single_ok: got %0d want 1", ok_cnt); end
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL single_err: got %b want 0", err); end
  endtask

  task automatic test_three();
    logic [15:0] c[3];
    clear_stats();
    foreach (c[i]) begin c[i] = 16'($urandom); push(c[i]); end
    do_start();
    run_until_done("three", 800);
    checks++; if (n_send !== 3) begin errors++; $display("FAIL three_nsend: got %0d want 3", n_send); end
    foreach (c[i]) begin
      checks++; if (sent_q[i] !== c[i]) begin errors++; $display("FAIL three_order%0d: got %h want %h", i, sent_q[i], c[i]); end
    end
    checks++; if (ok_cnt !== 8'd3)     begin errors++; $display("FAIL three_ok: got %0d want 3", ok_cnt); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL three_empty: got %b want 1", fifo_empty); end
    checks++; if (n_done !== 1)        begin errors++; $display("FAIL three_ndone: got %0d want 1", n_done); end
  endtask

  task automatic test_bad_resp();
    clear_stats();
    resp_list.push_back(ACK); resp_list.push_back(8'h5A);
    repeat (3) push(16'($urandom));
    do_start();
    run_until_done("bad", 800);
`ifdef REMOTE_CMD_SEQ_RETRY_EN
    checks++; if (n_send !== 4)        begin errors++; $display("FAIL bad_nsend: got %0d want 4", n_send); end
    checks++; if (ok_cnt !== 8'd3)     begin errors++; $display("FAIL bad_ok: got %0d want 3", ok_cnt); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL bad_err: got %b want 0", err); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL bad_empty: got %b want 1", fifo_empty); end
`else
    checks++; if (n_send !== 2)          begin errors++; $display("FAIL bad_nsend: got %0d want 2", n_send); end
    checks++; if (ok_cnt !== 8'd1)       begin errors++; $display("FAIL bad_ok: got %0d want 1", ok_cnt); end
    checks++; if (err !== 1'b1)          begin errors++; $display("FAIL bad_err: got %b want 1", err); end
    checks++; if (err_code !== 2'b10)    begin errors++; $display("FAIL bad_code: got %b want 10", err_code); end
    checks++; if (err_resp !== 8'h5A)    begin errors++; $display("FAIL bad_resp: got %h want 5a", err_resp); end
    checks++; if (fifo_empty !== 1'b0)   begin errors++; $display("FAIL bad_kept: got %b want 0", fifo_empty); end
`endif
    checks++; if (n_clr !== n_send) begin errors++; $display("FAIL bad_clr: got %0d want %0d", n_clr, n_send); end
    flush_idle();
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL bad_flush: got %b want 1", fifo_empty); end
  endtask

  task automatic test_timeout();
    clear_stats();
    no_resp = 1'b1;
    push(16'h1234);
    do_start();
    run_until_done("timeout", 1000);
    checks++; if (t_done !== t_send + TIMEOUT) begin errors++; $display("FAIL to_latency: got %0d want %0d", t_done - t_send, TIMEOUT); end
    checks++; if (n_send !== MAX_TRIES) begin errors++; $display("FAIL to_nsend: got %0d want %0d", n_send, MAX_TRIES); end
    checks++; if (err !== 1'b1)         begin errors++; $display("FAIL to_err: got %b want 1", err); end
    checks++; if (err_code !== 2'b01)   begin errors++; $display("FAIL to_code: got %b want 01", err_code); end
    checks++; if (err_resp !== 8'h00)   begin errors++; $display("FAIL to_resp: got %h want 00", err_resp); end
    checks++; if (n_clr !== 0)          begin errors++; $display("FAIL to_clr: got %0d want 0", n_clr); end
  endtask

  task automatic test_full_drop();
    logic [15:0] c[DEPTH+1];
    clear_stats();
    foreach (c[i]) begin c[i] = 16'h0A00 + 16'(i * 3); push(c[i]); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", fifo_full); end
    do_start();
    run_until_done("full", 2000);
    checks++; if (n_send !== DEPTH) begin errors++; $display("FAIL full_nsend: got %0d want %0d", n_send, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (sent_q[i] !== c[i]) begin errors++; $display("FAIL full_order%0d: got %h want %h", i, sent_q[i], c[i]); end
    end
    checks++; if (ok_cnt !== 8'(DEPTH)) begin errors++; $display("FAIL full_ok: got %0d want %0d", ok_cnt, DEPTH); end
    checks++; if (fifo_empty !== 1'b1)  begin errors++; $display("FAIL full_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_abort();
    int k = 0;
    clear_stats();
    auto_en = 1'b0;
    repeat (3) push(16'($urandom));
    do_start();
    while (n_send == 0 && k < 10) begin step(); k++; end
    checks++; if (n_send !== 1) begin errors++; $display("FAIL abort_send: got %0d want 1", n_send); end
    step();
    cmd_sent = 1'b1;
    step();
    resp = 8'h5A; resp_rdy = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0; resp_rdy = 1'b0;
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL abort_empty: got %b want 1", fifo_empty); end
    checks++; if (done !== 1'b1)       begin errors++; $display("FAIL abort_done: got %b want 1", done); end
    checks++; if (clr_rx_rdy !== 1'b1) begin errors++; $display("FAIL abort_clr: got %b want 1", clr_rx_rdy); end
    checks++; if (err !== 1'b0)        begin errors++; $display("FAIL abort_err: got %b want 0", err); end
    repeat (3) step();
    checks++; if (n_done !== 1 || n_clr !== 1) begin errors++; $display("FAIL abort_pulses: got done %0d clr %0d want 1 1", n_done, n_clr); end
  endtask

  task automatic test_random();
    logic [7:0] r;
    int n;
    for (int it = 0; it < 6; it++) begin
      clear_stats();
      noise_en = 1'b1;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) cmd_list.push_back(16'($urandom));
      for (int i = 0; i < n * MAX_TRIES; i++) begin
        r = 8'($urandom);
        if (r == ACK) r = 8'h00;
        resp_list.push_back(($urandom_range(0, 3) == 0) ? r : ACK);
      end
      model_run();
      foreach (cmd_list[i]) push(cmd_list[i]);
      do_start();
      run_until_done("rnd", 3000);
      checks++; if (n_send !== exp_sent.size()) begin errors++; $display("FAIL rnd%0d_nsend: got %0d want %0d", it, n_send, exp_sent.size()); end
      foreach (exp_sent[i]) begin
        checks++; if (sent_q[i] !== exp_sent[i]) begin errors++; $display("FAIL rnd%0d_cmd%0d: got %h want %h", it, i, sent_q[i], exp_sent[i]); end
      end
      checks++; if (ok_cnt !== 8'(exp_ok)) begin errors++; $display("FAIL rnd%0d_ok: got %0d want %0d", it, ok_cnt, exp_ok); end
      checks++; if (err !== exp_err || err_code !== exp_code || err_resp !== exp_eresp) begin
        errors++; $display("FAIL rnd%0d_err: got %b/%b/%h want %b/%b/%h", it, err, err_code, err_resp, exp_err, exp_code, exp_eresp);
      end
      checks++; if (n_clr !== exp_sent.size()) begin errors++; $display("FAIL rnd%0d_clr: got %0d want %0d", it, n_clr, exp_sent.size()); end
      checks++; if (fifo_empty !== (exp_left == 0)) begin errors++; $display("FAIL rnd%0d_left: got empty=%b want %b", it, fifo_empty, exp_left == 0); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL rnd%0d_ndone: got %0d want 1", it, n_done); end
      flush_idle();
    end
  endtask

  task automatic test_rst_mid_send();
    int k = 0;
    clear_stats();
    repeat (3) push(16'hBEEF);
    do_start();
    while (n_send < 2 && k < 200) begin step(); k++; end
    checks++; if (send_cmd !== 1'b1 || ok_cnt !== 8'd1) begin errors++; $display("FAIL rstm_pre: got send %b ok %0d want 1 1", send_cmd, ok_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || send_cmd !== 1'b0) begin errors++; $display("FAIL rstm_ctl: got busy %b send %b want 0 0", busy, send_cmd); end
    checks++; if (cmd !== 16'h0)       begin errors++; $display("FAIL rstm_cmd: got %h want 0", cmd); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rstm_empty: got %b want 1", fifo_empty); end
    checks++; if (ok_cnt !== 8'h0)     begin errors++; $display("FAIL rstm_ok: got %0d want 0", ok_cnt); end
    checks++; if (done !== 1'b0 || err !== 1'b0 || clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL rstm_misc: got done %b err %b clr %b want 0 0 0", done, err, clr_rx_rdy); end
    @(negedge clk);
    auto_en = 1'b0; resp_rdy = 1'b0; cmd_sent = 1'b0; phase = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_in = '0; cmd_wr = 1'b0; start = 1'b0; abort = 1'b0;
    cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0; t_start = 0;
    clear_stats();
    auto_en = 1'b0;
    test_reset();
    test_empty_start();
    test_single();
    test_three();
    test_bad_resp();
    test_timeout();
    test_full_drop();
    test_abort();
    test_random();
    test_rst_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
